// File: rtl/mem_stage_pkg.sv
// Shared widths, exception codes and bus layouts for the memory stage.
// Field order in each struct is MSB first and must match the neighbouring stages.
package mem_stage_pkg;

    localparam int unsigned ES_TO_MS_BUS_WD = 161;
    localparam int unsigned MS_TO_WS_BUS_WD = 155;
    localparam int unsigned MS_TO_DS_FWD_WD = 39;

    localparam logic [4:0] EX_INT  = 5'h00;
    localparam logic [4:0] EX_ADEL = 5'h04;
    localparam logic [4:0] EX_ADES = 5'h05;
    localparam logic [4:0] EX_SYS  = 5'h08;
    localparam logic [4:0] EX_BP   = 5'h09;
    localparam logic [4:0] EX_RI   = 5'h0a;
    localparam logic [4:0] EX_OV   = 5'h0c;

    typedef struct packed {
        logic        ex;
        logic [4:0]  exccode;
        logic        bd;
        logic [31:0] badvaddr;
        logic        eret;
        logic        mtc0;
        logic [7:0]  cp0_addr;
        logic [31:0] cp0_wdata;
        logic        res_from_cp0;
        logic        res_from_mem;
        logic [1:0]  addr_low;
        logic        lb;
        logic        lbu;
        logic        lh;
        logic        lhu;
        logic        lwl;
        logic        lwr;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        ex;
        logic [4:0]  exccode;
        logic        bd;
        logic [31:0] badvaddr;
        logic        eret;
        logic        mtc0;
        logic [7:0]  cp0_addr;
        logic [31:0] cp0_wdata;
        logic        res_from_cp0;
        logic [3:0]  rf_wstrb;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data extraction: sign/zero extension for byte/half loads and the
// partial-word data plus byte strobe for lwl/lwr.
module mem_stage_load_align (
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_low,
    input  logic        i_lb,
    input  logic        i_lbu,
    input  logic        i_lh,
    input  logic        i_lhu,
    input  logic        i_lwl,
    input  logic        i_lwr,
    output logic [31:0] o_data,
    output logic [3:0]  o_strobe
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rdata >> {i_addr_low, 3'b000};

    always_comb begin
        o_data   = i_rdata;
        o_strobe = 4'b1111;
        if (i_lb) begin
            o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
        end else if (i_lbu) begin
            o_data = {24'b0, w_shifted[7:0]};
        end else if (i_lh) begin
            o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
        end else if (i_lhu) begin
            o_data = {16'b0, w_shifted[15:0]};
        end else if (i_lwl) begin
            unique case (i_addr_low)
                2'd0: begin o_data = {i_rdata[7:0], 24'b0};  o_strobe = 4'b1000; end
                2'd1: begin o_data = {i_rdata[15:0], 16'b0}; o_strobe = 4'b1100; end
                2'd2: begin o_data = {i_rdata[23:0], 8'b0};  o_strobe = 4'b1110; end
                default: begin o_data = i_rdata;             o_strobe = 4'b1111; end
            endcase
        end else if (i_lwr) begin
            unique case (i_addr_low)
                2'd0: begin o_data = i_rdata;                 o_strobe = 4'b1111; end
                2'd1: begin o_data = {8'b0, i_rdata[31:8]};   o_strobe = 4'b0111; end
                2'd2: begin o_data = {16'b0, i_rdata[31:16]}; o_strobe = 4'b0011; end
                default: begin o_data = {24'b0, i_rdata[31:24]}; o_strobe = 4'b0001; end
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: latches the execute bus, waits for load data (with a one-entry
// read buffer for back-pressure) and presents write-back and forwarding buses.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       data_sram_data_ok,
    output logic                       ms_handle_ex,
    input  logic                       ws_handle_ex,
    output logic [MS_TO_DS_FWD_WD-1:0] ms_to_ds_fwd
);

    es_to_ms_t   r_bus;
    logic        r_ms_valid;
    logic        r_buf_valid;
    logic [31:0] r_buf_data;

    logic        w_need_data;
    logic        w_have_data;
    logic        w_ready_go;
    logic        w_handoff;
    logic [31:0] w_rdata;
    logic [31:0] w_load_data;
    logic [3:0]  w_strobe;
    logic [31:0] w_final_result;
    logic        w_fwd_we;
    logic        w_fwd_block;
    ms_to_ws_t   w_ws;

    assign w_need_data    = r_ms_valid && r_bus.res_from_mem && !r_bus.ex;
    assign w_have_data    = r_buf_valid || data_sram_data_ok;
    assign w_ready_go     = !(w_need_data && !w_have_data);
    assign ms_allowin     = !r_ms_valid || (w_ready_go && ws_allowin);
    assign ms_to_ws_valid = r_ms_valid && w_ready_go;
    assign w_handoff      = ms_to_ws_valid && ws_allowin;
    assign w_rdata        = r_buf_valid ? r_buf_data : data_sram_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_valid <= 1'b0;
        end else if (ws_handle_ex) begin
            r_ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            r_ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bus <= '0;
        end else if (es_to_ms_valid && ms_allowin) begin
            r_bus <= es_to_ms_t'(es_to_ms_bus);
        end
    end

    // Only capture when the load cannot leave this cycle; later data_ok pulses are ignored.
    always_ff @(posedge clk) begin
        if (reset || w_handoff || ws_handle_ex) begin
            r_buf_valid <= 1'b0;
            r_buf_data  <= '0;
        end else if (w_need_data && data_sram_data_ok && !r_buf_valid) begin
            r_buf_valid <= 1'b1;
            r_buf_data  <= data_sram_rdata;
        end
    end

    mem_stage_load_align u_load_align (
        .i_rdata    (w_rdata),
        .i_addr_low (r_bus.addr_low),
        .i_lb       (r_bus.lb),
        .i_lbu      (r_bus.lbu),
        .i_lh       (r_bus.lh),
        .i_lhu      (r_bus.lhu),
        .i_lwl      (r_bus.lwl),
        .i_lwr      (r_bus.lwr),
        .o_data     (w_load_data),
        .o_strobe   (w_strobe)
    );

    assign w_final_result = r_bus.res_from_mem ? w_load_data : r_bus.alu_result;

    always_comb begin
        w_ws              = '0;
        w_ws.ex           = r_bus.ex;
        w_ws.exccode      = r_bus.exccode;
        w_ws.bd           = r_bus.bd;
        w_ws.badvaddr     = r_bus.badvaddr;
        w_ws.eret         = r_bus.eret;
        w_ws.mtc0         = r_bus.mtc0;
        w_ws.cp0_addr     = r_bus.cp0_addr;
        w_ws.cp0_wdata    = r_bus.cp0_wdata;
        w_ws.res_from_cp0 = r_bus.res_from_cp0;
        w_ws.rf_wstrb     = (r_bus.gr_we && !r_bus.ex) ? w_strobe : 4'b0000;
        w_ws.dest         = r_bus.dest;
        w_ws.final_result = w_final_result;
        w_ws.pc           = r_bus.pc;
    end

    assign ms_to_ws_bus = w_ws;
    assign ms_handle_ex = r_ms_valid && (r_bus.ex || r_bus.eret);

    // Partial writes and CP0 reads cannot be forwarded as a full word, so decode must stall.
    assign w_fwd_we    = r_ms_valid && r_bus.gr_we && (r_bus.dest != 5'd0);
    assign w_fwd_block = r_ms_valid && (r_bus.res_from_cp0 || r_bus.lwl || r_bus.lwr ||
                                        (w_need_data && !w_have_data));
    assign ms_to_ds_fwd = {w_fwd_we, w_fwd_block, r_bus.dest, w_final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load extraction, late data, buffered data,
// lwl/lwr, exceptions, flush and reset during a pending load.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       ws_allowin;
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [31:0]                data_sram_rdata;
    logic                       data_sram_data_ok;
    logic                       ms_handle_ex;
    logic                       ws_handle_ex;
    logic [MS_TO_DS_FWD_WD-1:0] ms_to_ds_fwd;

    ms_to_ws_t wsb;
    es_to_ms_t b;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign wsb = ms_to_ws_t'(ms_to_ws_bus);

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_rdata   (data_sram_rdata),
        .data_sram_data_ok (data_sram_data_ok),
        .ms_handle_ex      (ms_handle_ex),
        .ws_handle_ex      (ws_handle_ex),
        .ms_to_ds_fwd      (ms_to_ds_fwd)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Offer one instruction for one cycle; returns #1 after the following negedge.
    task automatic issue(input es_to_ms_t ib);
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = ib;
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset             = 1'b1;
        ws_allowin        = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        data_sram_rdata   = '0;
        data_sram_data_ok = 1'b1;
        ws_handle_ex      = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", 64'(ms_to_ws_valid), 64'd0);
        check("rst_allowin", 64'(ms_allowin), 64'd1);
        check("rst_handle_ex", 64'(ms_handle_ex), 64'd0);
        check("rst_fwd", 64'(ms_to_ds_fwd), 64'd0);
        check("rst_buf", 64'(dut.r_buf_valid), 64'd0);
        reset = 1'b0;

        // lb from byte 2, data_ok already high
        data_sram_rdata = 32'h1280_FF00;
        b = '0; b.res_from_mem = 1'b1; b.lb = 1'b1; b.gr_we = 1'b1; b.dest = 5'd5;
        b.addr_low = 2'd2; b.pc = 32'hBFC0_0100;
        issue(b);
        check("lb_valid", 64'(ms_to_ws_valid), 64'd1);
        check("lb_result", 64'(wsb.final_result), 64'hFFFF_FF80);
        check("lb_wstrb", 64'(wsb.rf_wstrb), 64'hF);
        check("lb_pc", 64'(wsb.pc), 64'hBFC0_0100);
        check("lb_fwd", 64'(ms_to_ds_fwd), {25'd0, 1'b1, 1'b0, 5'd5, 32'hFFFF_FF80});
        step();
        check("lb_gone", 64'(ms_to_ws_valid), 64'd0);

        // lhu with data_ok three cycles late
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hABCD_8001;
        b = '0; b.res_from_mem = 1'b1; b.lhu = 1'b1; b.gr_we = 1'b1; b.dest = 5'd6;
        issue(b);
        check("lhu_wait0", 64'(ms_to_ws_valid), 64'd0);
        check("lhu_block", 64'(ms_to_ds_fwd[37]), 64'd1);
        check("lhu_allowin", 64'(ms_allowin), 64'd0);
        step();
        check("lhu_wait1", 64'(ms_to_ws_valid), 64'd0);
        step();
        check("lhu_wait2", 64'(ms_to_ws_valid), 64'd0);
        @(negedge clk);
        data_sram_data_ok = 1'b1;
        #1;
        check("lhu_valid", 64'(ms_to_ws_valid), 64'd1);
        check("lhu_result", 64'(wsb.final_result), 64'h0000_8001);
        check("lhu_noblock", 64'(ms_to_ds_fwd[37]), 64'd0);
        step();
        check("lhu_gone", 64'(ms_to_ws_valid), 64'd0);
        check("lhu_nocapture", 64'(dut.r_buf_valid), 64'd0);

        // lw whose data arrives while write-back stalls
        data_sram_rdata = 32'hDEAD_BEEF;
        b = '0; b.res_from_mem = 1'b1; b.gr_we = 1'b1; b.dest = 5'd8;
        issue(b);
        ws_allowin = 1'b0;
        #1;
        check("lw_bp_valid", 64'(ms_to_ws_valid), 64'd1);
        check("lw_bp_allowin", 64'(ms_allowin), 64'd0);
        @(negedge clk);
        data_sram_rdata   = 32'h0;
        data_sram_data_ok = 1'b0;
        #1;
        check("lw_buf_valid", 64'(dut.r_buf_valid), 64'd1);
        check("lw_buf_res1", 64'(wsb.final_result), 64'hDEAD_BEEF);
        check("lw_buf_ready", 64'(ms_to_ws_valid), 64'd1);
        step();
        check("lw_buf_res2", 64'(wsb.final_result), 64'hDEAD_BEEF);
        @(negedge clk);
        ws_allowin = 1'b1;
        #1;
        check("lw_buf_res3", 64'(wsb.final_result), 64'hDEAD_BEEF);
        check("lw_buf_allowin", 64'(ms_allowin), 64'd1);
        step();
        check("lw_buf_clear", 64'(dut.r_buf_valid), 64'd0);
        check("lw_buf_gone", 64'(ms_to_ws_valid), 64'd0);

        // lwl / lwr / lh / lbu / plain ALU result
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1122_3344;
        b = '0; b.res_from_mem = 1'b1; b.lwl = 1'b1; b.gr_we = 1'b1; b.dest = 5'd7;
        b.addr_low = 2'd1;
        issue(b);
        check("lwl_result", 64'(wsb.final_result), 64'h3344_0000);
        check("lwl_wstrb", 64'(wsb.rf_wstrb), 64'b1100);
        check("lwl_block", 64'(ms_to_ds_fwd[37]), 64'd1);
        b = '0; b.res_from_mem = 1'b1; b.lwr = 1'b1; b.gr_we = 1'b1; b.dest = 5'd7;
        b.addr_low = 2'd2;
        issue(b);
        check("lwr_result", 64'(wsb.final_result), 64'h0000_1122);
        check("lwr_wstrb", 64'(wsb.rf_wstrb), 64'b0011);
        data_sram_rdata = 32'h8001_7FFF;
        b = '0; b.res_from_mem = 1'b1; b.lh = 1'b1; b.gr_we = 1'b1; b.dest = 5'd9;
        b.addr_low = 2'd2;
        issue(b);
        check("lh_result", 64'(wsb.final_result), 64'hFFFF_8001);
        data_sram_rdata = 32'hC300_0000;
        b = '0; b.res_from_mem = 1'b1; b.lbu = 1'b1; b.gr_we = 1'b1; b.dest = 5'd9;
        b.addr_low = 2'd3;
        issue(b);
        check("lbu_result", 64'(wsb.final_result), 64'h0000_00C3);
        b = '0; b.alu_result = 32'h1234_5678; b.gr_we = 1'b1; b.dest = 5'd0;
        issue(b);
        check("alu_result", 64'(wsb.final_result), 64'h1234_5678);
        check("alu_fwd_r0", 64'(ms_to_ds_fwd[38]), 64'd0);

        // Excepting load must not wait for data
        data_sram_data_ok = 1'b0;
        b = '0; b.ex = 1'b1; b.exccode = EX_ADEL; b.res_from_mem = 1'b1; b.gr_we = 1'b1;
        b.dest = 5'd3;
        issue(b);
        check("ex_valid", 64'(ms_to_ws_valid), 64'd1);
        check("ex_handle", 64'(ms_handle_ex), 64'd1);
        check("ex_wstrb", 64'(wsb.rf_wstrb), 64'd0);
        check("ex_code", 64'({wsb.ex, wsb.exccode}), {58'd0, 1'b1, EX_ADEL});

        // Flush drops an instruction that write-back is stalling
        data_sram_data_ok = 1'b1;
        b = '0; b.alu_result = 32'h5; b.gr_we = 1'b1; b.dest = 5'd4;
        issue(b);
        ws_allowin   = 1'b0;
        ws_handle_ex = 1'b1;
        #1;
        check("flush_pre", 64'(ms_to_ws_valid), 64'd1);
        @(negedge clk);
        ws_handle_ex = 1'b0;
        #1;
        check("flush_valid", 64'(ms_to_ws_valid), 64'd0);
        check("flush_fwd_we", 64'(ms_to_ds_fwd[38]), 64'd0);
        ws_allowin = 1'b1;

        // Reset while a load waits for data
        data_sram_data_ok = 1'b0;
        b = '0; b.res_from_mem = 1'b1; b.gr_we = 1'b1; b.dest = 5'd10;
        issue(b);
        check("rw_wait", 64'(ms_to_ws_valid), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset             = 1'b0;
        data_sram_data_ok = 1'b1;
        #1;
        check("rw_valid", 64'(ms_to_ws_valid), 64'd0);
        check("rw_allowin", 64'(ms_allowin), 64'd1);
        check("rw_fwd", 64'(ms_to_ds_fwd), 64'd0);
        check("rw_handle_ex", 64'(ms_handle_ex), 64'd0);
        check("rw_buf", 64'(dut.r_buf_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
